// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_pkg : shared types and helpers for the register-file write path   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rf_pkg;

  localparam int RF_ADDR_W   = 4;
  localparam int RF_DATA_W   = 16;
  localparam int RF_NUM_REGS = 16;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_req_t;

  function automatic logic [RF_NUM_REGS-1:0] onehot_addr(input logic [RF_ADDR_W-1:0] addr);
    onehot_addr       = '0;
    onehot_addr[addr] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_wb_arbiter_if : ALU / accelerator / register-file write bundle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface rf_wb_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic                   alu_v_i;
  logic [ADDR_W-1:0]      alu_addr_i;
  logic [DATA_W-1:0]      alu_data_i;
  logic                   alu_ready_o;
  logic                   acc_v_i;
  logic [ADDR_W-1:0]      acc_addr_i;
  logic [DATA_W-1:0]      acc_data_i;
  logic                   acc_ready_o;
  logic                   wr_en_o;
  logic [ADDR_W-1:0]      wr_addr_o;
  logic [DATA_W-1:0]      wr_data_o;
  logic [2**ADDR_W-1:0]   pending_o;
  logic [$clog2(DEPTH):0] fifo_count_o;

  modport slave (
    input  alu_v_i, alu_addr_i, alu_data_i, acc_v_i, acc_addr_i, acc_data_i,
    output alu_ready_o, acc_ready_o, wr_en_o, wr_addr_o, wr_data_o, pending_o, fifo_count_o
  );

  modport master (
    output alu_v_i, alu_addr_i, alu_data_i, acc_v_i, acc_addr_i, acc_data_i,
    input  alu_ready_o, acc_ready_o, wr_en_o, wr_addr_o, wr_data_o, pending_o, fifo_count_o
  );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_wb_fifo : accelerator write-back FIFO with per-entry address view |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                   clk_i,
  input  wire logic                   reset_n_i,
  input  wire logic                   push_i,
  input  wire rf_wr_req_t             push_req_i,
  input  wire logic                   pop_i,
  output rf_wr_req_t                  head_o,
  output logic [$clog2(DEPTH):0]      count_o,
  output logic [DEPTH-1:0]            entry_valid_o,
  output logic [RF_ADDR_W-1:0]        entry_addr_o [DEPTH]
);
  localparam int c_PTR_W = $clog2(DEPTH);

  rf_wr_req_t         r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic [DEPTH-1:0]   r_valid;

  // Storage needs no reset; r_valid alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr_ptr] <= push_req_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (pop_i) begin
        r_rd_ptr          <= r_rd_ptr + 1'b1;
        r_valid[r_rd_ptr] <= 1'b0;
      end
      if (push_i) begin
        r_wr_ptr          <= r_wr_ptr + 1'b1;
        r_valid[r_wr_ptr] <= 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o        = r_mem[r_rd_ptr];
  assign count_o       = r_count;
  assign entry_valid_o = r_valid;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_addr
    assign entry_addr_o[gi] = r_mem[gi].addr;
  end
endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rf_wb_arbiter : merges ALU and accelerator write-backs onto RF port  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int DATA_W     = RF_DATA_W,
  parameter int STARVE_MAX = 3
) (
  input wire logic       clk_i,
  input wire logic       reset_n_i,
  rf_wb_arbiter_if.slave bus
);
  localparam int c_CNT_W    = $clog2(DEPTH) + 1;
  localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);

  logic [c_STARVE_W-1:0] r_starve;
  logic                  r_wr_en;
  logic [ADDR_W-1:0]     r_wr_addr;
  logic [DATA_W-1:0]     r_wr_data;

  rf_wr_req_t           w_head;
  rf_wr_req_t           w_push_req;
  logic [c_CNT_W-1:0]   w_count;
  logic [DEPTH-1:0]     w_entry_valid;
  logic [ADDR_W-1:0]    w_entry_addr [DEPTH];
  logic                 w_fifo_ne;
  logic                 w_force;
  logic                 w_alu_ready;
  logic                 w_acc_ready;
  logic                 w_alu_grant;
  logic                 w_pop;
  logic                 w_push;
  logic [2**ADDR_W-1:0] w_pending;

  assign w_fifo_ne   = (w_count != '0);
  assign w_force     = w_fifo_ne && (r_starve == c_STARVE_W'(STARVE_MAX));
  assign w_alu_ready = reset_n_i && !w_force;
  assign w_acc_ready = reset_n_i && (w_count < c_CNT_W'(DEPTH));
  assign w_alu_grant = bus.alu_v_i && w_alu_ready;
  // The head drains when the ALU is idle or has starved it long enough.
  assign w_pop       = reset_n_i && w_fifo_ne && (w_force || !bus.alu_v_i);
  assign w_push      = bus.acc_v_i && w_acc_ready;
  assign w_push_req  = '{addr: bus.acc_addr_i, data: bus.acc_data_i};

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .push_i        (w_push),
    .push_req_i    (w_push_req),
    .pop_i         (w_pop),
    .head_o        (w_head),
    .count_o       (w_count),
    .entry_valid_o (w_entry_valid),
    .entry_addr_o  (w_entry_addr)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_starve  <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_pop || !w_fifo_ne) r_starve <= '0;
      else                     r_starve <= r_starve + 1'b1;
      r_wr_en <= w_alu_grant || w_pop;
      if (w_alu_grant) begin
        r_wr_addr <= bus.alu_addr_i;
        r_wr_data <= bus.alu_data_i;
      end else if (w_pop) begin
        r_wr_addr <= w_head.addr;
        r_wr_data <= w_head.data;
      end
    end
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_valid[i]) w_pending = w_pending | onehot_addr(w_entry_addr[i]);
    end
    if (r_wr_en) w_pending = w_pending | onehot_addr(r_wr_addr);
  end

  assign bus.alu_ready_o  = w_alu_ready;
  assign bus.acc_ready_o  = w_acc_ready;
  assign bus.wr_en_o      = r_wr_en;
  assign bus.wr_addr_o    = r_wr_addr;
  assign bus.wr_data_o    = r_wr_data;
  assign bus.pending_o    = w_pending;
  assign bus.fifo_count_o = w_count;
endmodule
`default_nettype wire
